// File: rtl/freq_out_cfg_pkg.sv
// Shared types and constants for the freq_out register configuration sequencer.
`timescale 1ns/1ps
package freq_out_cfg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdAddr,
    StRdData,
    StFin
  } state_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrSlave    = 2'd1,
    ErrMismatch = 2'd2,
    ErrTimeout  = 2'd3
  } err_e;

  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam int unsigned REG_STRIDE = 4;

endpackage

// File: rtl/freq_out_cfg_wdog.sv
// Handshake watchdog: counts cycles spent waiting in a phase, flags expiry after Timeout cycles.
`timescale 1ns/1ps
module freq_out_cfg_wdog #(
  parameter int unsigned Timeout = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned     CntW   = (Timeout > 1) ? $clog2(Timeout) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Timeout - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Count value k means this is the (k+1)-th cycle of the current wait.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == CntMax);

endmodule

// File: rtl/freq_out_cfg_seq.sv
// AXI4-Lite master that writes C_NUM_REGS freq_out registers, reads them back and verifies them.
`timescale 1ns/1ps
module freq_out_cfg_seq
  import freq_out_cfg_pkg::*;
#(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned                   C_M_AXI_DATA_WIDTH = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR        = '0,
  parameter int unsigned                   C_NUM_REGS         = 4,
  parameter int unsigned                   C_TIMEOUT          = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic                            start,
  input  logic [32*C_NUM_REGS-1:0]        cfg_data,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      err_code,
  output logic [1:0]                      err_index,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam logic [1:0] LastIdx = 2'(C_NUM_REGS - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  err_e        err_q, err_d;
  logic [1:0]  err_idx_q, err_idx_d;
  logic [31:0] cfg_q [C_NUM_REGS];
  logic        cfg_load;

  logic        wdog_load, wdog_en, wdog_expired;
  logic        aw_done, w_done, last_idx;
  logic [C_M_AXI_ADDR_WIDTH-1:0] reg_addr;

  // A channel counts as done once its VALID has dropped or it handshakes this cycle.
  assign aw_done  = !awvalid_q || M_AXI_AWREADY;
  assign w_done   = !wvalid_q || M_AXI_WREADY;
  assign last_idx = (idx_q == LastIdx);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    cfg_load  = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          cfg_load  = 1'b1;
          idx_d     = '0;
          err_d     = ErrNone;
          err_idx_d = '0;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = StWr;
        end
      end

      StWr: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d = StWrResp;
        end else if (wdog_expired) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          err_d     = ErrTimeout;
          err_idx_d = idx_q;
          state_d   = StFin;
        end
      end

      StWrResp: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != RESP_OKAY) begin
            err_d     = ErrSlave;
            err_idx_d = idx_q;
            state_d   = StFin;
          end else if (last_idx) begin
            idx_d     = '0;
            arvalid_d = 1'b1;
            state_d   = StRdAddr;
          end else begin
            idx_d     = idx_q + 2'd1;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWr;
          end
        end else if (wdog_expired) begin
          err_d     = ErrTimeout;
          err_idx_d = idx_q;
          state_d   = StFin;
        end
      end

      StRdAddr: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = StRdData;
        end else if (wdog_expired) begin
          arvalid_d = 1'b0;
          err_d     = ErrTimeout;
          err_idx_d = idx_q;
          state_d   = StFin;
        end
      end

      StRdData: begin
        if (M_AXI_RVALID) begin
          // A bad response outranks a data mismatch on the same beat.
          if (M_AXI_RRESP != RESP_OKAY) begin
            err_d     = ErrSlave;
            err_idx_d = idx_q;
            state_d   = StFin;
          end else if (M_AXI_RDATA != cfg_q[idx_q]) begin
            err_d     = ErrMismatch;
            err_idx_d = idx_q;
            state_d   = StFin;
          end else if (last_idx) begin
            state_d = StFin;
          end else begin
            idx_d     = idx_q + 2'd1;
            arvalid_d = 1'b1;
            state_d   = StRdAddr;
          end
        end else if (wdog_expired) begin
          err_d     = ErrTimeout;
          err_idx_d = idx_q;
          state_d   = StFin;
        end
      end

      StFin: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      err_q     <= ErrNone;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int unsigned i = 0; i < C_NUM_REGS; i++) cfg_q[i] <= '0;
    end else if (cfg_load) begin
      for (int unsigned i = 0; i < C_NUM_REGS; i++) cfg_q[i] <= cfg_data[32*i +: 32];
    end
  end

  // Every state change reloads the watchdog, so each wait phase gets a fresh budget.
  assign wdog_load = (state_d != state_q);
  assign wdog_en   = (state_q == StWr) || (state_q == StWrResp) ||
                     (state_q == StRdAddr) || (state_q == StRdData);

  freq_out_cfg_wdog #(
    .Timeout (C_TIMEOUT)
  ) u_wdog (
    .clk_i     (ACLK),
    .rst_ni    (ARESETN),
    .load_i    (wdog_load),
    .en_i      (wdog_en),
    .expired_o (wdog_expired)
  );

  assign reg_addr = C_BASE_ADDR +
                    C_M_AXI_ADDR_WIDTH'(idx_q) * C_M_AXI_ADDR_WIDTH'(REG_STRIDE);

  assign M_AXI_AWADDR  = reg_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = cfg_q[idx_q];
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == StWrResp);
  assign M_AXI_ARADDR  = reg_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state_q == StRdData);

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);
  assign err_code  = err_q;
  assign err_index = err_idx_q;

endmodule

// File: doc/freq_out_cfg_seq.md
FREQ_OUT_CFG_SEQ -- requirements
Module: freq_out_cfg_seq

Interface
REQ-001 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32: AXI4-Lite address width.
REQ-002 SHALL have parameter C_M_AXI_DATA_WIDTH, default 32: data width; only 32 is supported.
REQ-003 SHALL have parameter C_BASE_ADDR, default 32'h0000_0000: freq_out register base.
REQ-004 SHALL have parameter C_NUM_REGS, default 4: registers programmed, 1..4.
REQ-005 SHALL have parameter C_TIMEOUT, default 1024: maximum wait cycles per handshake phase.
REQ-006 SHALL have port ACLK, input, 1: the single clock; all logic is rising-edge.
REQ-007 SHALL have port ARESETN, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1: a 1-cycle pulse that launches a sequence.
REQ-009 SHALL have port cfg_data, input, 32*C_NUM_REGS: register values; register i is bits [32i+31:32i].
REQ-010 SHALL have port busy, output, 1: a sequence is in progress.
REQ-011 SHALL have port done, output, 1: a 1-cycle pulse at sequence end.
REQ-012 SHALL have port err_code, output, 2: 0 none, 1 slave response, 2 readback mismatch, 3 timeout.
REQ-013 SHALL have port err_index, output, 2: register index of the first error.
REQ-014 SHALL have the full AXI4-Lite master port set M_AXI_AW*, W*, B*, AR*, R*, with widths per parameters.

Function
REQ-015 SHALL accept start only in IDLE; start while busy is ignored.
REQ-016 SHALL capture cfg_data into an internal array on the accepted start cycle; later cfg_data changes have no effect.
REQ-017 SHALL use FSM states IDLE -> WR (AW and W) -> WR_RESP -> (next index, or RD at the last index) -> RD_ADDR -> RD_DATA -> (next index, or FIN) -> FIN -> IDLE.
REQ-018 SHALL assert AWVALID and WVALID together on entering WR.
REQ-019 SHALL drop each of AWVALID and WVALID independently on its own handshake.
REQ-020 SHALL leave WR only when both handshakes have completed, in either order or in the same cycle.
REQ-021 SHALL drive AWADDR/ARADDR = C_BASE_ADDR + 4*idx, WSTRB = 4'hF, and AWPROT = ARPROT = 3'b000.
REQ-022 SHALL assert BREADY only in WR_RESP and RREADY only in RD_DATA.
REQ-023 SHALL never deassert a VALID signal before its handshake.
REQ-024 SHALL write all C_NUM_REGS registers before issuing any read.
REQ-025 SHALL read the registers in ascending index order.
REQ-026 SHALL compare each RDATA with the captured value.
REQ-027 SHALL abort to FIN on the first error and latch err_code and err_index there.
REQ-028 SHALL treat a BRESP or RRESP other than OKAY as code 1, which takes precedence over a mismatch on the same beat (code 2).
REQ-029 SHALL reload the timeout counter on entry to each of WR, WR_RESP, RD_ADDR and RD_DATA.
REQ-030 SHALL abort with code 3 after C_TIMEOUT cycles without the awaited handshake; all VALID outputs drop in that transition.
REQ-031 SHALL pulse done for exactly 1 cycle in FIN, then return to IDLE.
REQ-032 SHALL hold busy high from the cycle after an accepted start through FIN inclusive.
REQ-033 SHALL hold err_code and err_index until the next accepted start, which clears them.
REQ-034 SHALL support at most one outstanding transaction; the total is 2*C_NUM_REGS transactions when error-free.

Reset
REQ-035 SHALL, while ARESETN is low, force state IDLE, all VALID/READY outputs 0, busy 0, done 0, err_code 0, err_index 0, and the index and timeout counters to 0.
REQ-036 SHALL, on reset mid-sequence, drop outstanding VALIDs immediately; it does not complete the in-flight transaction.
REQ-037 SHALL accept start on the first rising ACLK edge after ARESETN deasserts.

Structure
REQ-038 SHALL place the FSM state enum, the err_code enum, the RESP_OKAY constant (2'b00) and the register stride constant (4) in package freq_out_cfg_pkg.
REQ-039 SHALL implement the timeout counter as sub-module freq_out_cfg_wdog (load, enable, expired), instantiated once.
REQ-040 SHALL consist of no other sub-modules and contain no combinational path from any AXI input to any AXI output.

Verification
REQ-041 SHALL verify the nominal sequence: start with cfg_data {4,3,2,1}, zero-latency slave -> 4 writes to 0x0/0x4/0x8/0xC with data 1,2,3,4, then 4 reads, one done pulse, err_code 0.
REQ-042 SHALL verify skewed handshakes: AWREADY on cycle 1 and WREADY on cycle 5 of WR -> AWVALID drops after cycle 1, exactly one write, sequence completes.
REQ-043 SHALL verify slave error: BRESP = SLVERR on the write to 0x8 -> err_code 1, err_index 2, no AR issued, done pulses.
REQ-044 SHALL verify readback mismatch: RDATA 0xDEAD_BEEF at 0xC -> err_code 2, err_index 3.
REQ-045 SHALL verify timeout: ARREADY held low -> after 1024 cycles err_code 3, ARVALID drops, done pulses.
REQ-046 SHALL verify reset mid-operation: ARESETN low during WR_RESP of index 1 -> all outputs reach reset values asynchronously, and a following start runs the full nominal sequence.
